muldiv_sequencer: RTL and testbench

- Multi-cycle controller and datapath for the RV32M extension. It executes the op_reg instructions that the decode stage marks with muldiv_en.
- Sits beside the ALU in EX. It captures operands, runs an iterative shift-add multiply or restoring divide, and stalls the pipeline until the result is ready.
- Hands the result to the EX/MEM register when the pipeline advances.

---
 rtl/muldiv_sequencer_pkg.sv | 18 +
 rtl/muldiv_core.sv | 60 ++++++
 rtl/muldiv_sequencer.sv | 122 ++++++++++++
 tb/tb_muldiv_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared RV32 types for the M-extension sequencer: funct3 op encoding and
// the dividend value that overflows a signed divide by -1.
package rv32i_types;

  typedef enum logic [2:0] {
    mul    = 3'b000,
    mulh   = 3'b001,
    mulhsu = 3'b010,
    mulhu  = 3'b011,
    div    = 3'b100,
    divu   = 3'b101,
    rem    = 3'b110,
    remu   = 3'b111
  } muldiv_funct3_t;

  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: 2*XLEN accumulator plus step counter. Multiply keeps
// {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
module muldiv_core #(
  parameter int XLEN  = 32,
  parameter int STEPS = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load,
  input  logic                               is_div,
  input  logic [XLEN-1:0]                    init_lo,
  input  logic [XLEN-1:0]                    init_m,
  input  logic                               calc,
  output logic [2*XLEN-1:0]                  acc,
  output logic [$clog2(XLEN/STEPS+1)-1:0]    cnt
);

  localparam int CW = $clog2(XLEN/STEPS+1);

  logic [XLEN-1:0]   m;
  logic              is_div_q;
  logic [2*XLEN-1:0] acc_nxt;
  logic [XLEN:0]     trial;
  logic [XLEN:0]     sum;

  always_comb begin
    acc_nxt = acc;
    trial   = '0;
    sum     = '0;
    for (int i = 0; i < STEPS; i++) begin
      if (is_div_q) begin
        // trial uses the bit shifted out of the remainder, so a divisor near 2^XLEN still fits
        trial = acc_nxt[2*XLEN-1:XLEN-1] - {1'b0, m};
        if (!trial[XLEN]) acc_nxt = {trial[XLEN-1:0], acc_nxt[XLEN-2:0], 1'b1};
        else              acc_nxt = {acc_nxt[2*XLEN-2:0], 1'b0};
      end else begin
        sum     = {1'b0, acc_nxt[2*XLEN-1:XLEN]} + ({1'b0, m} & {(XLEN+1){acc_nxt[0]}});
        acc_nxt = {sum, acc_nxt[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      m        <= '0;
      cnt      <= '0;
      is_div_q <= 1'b0;
    end else if (load) begin
      acc      <= {{XLEN{1'b0}}, init_lo};
      m        <= init_m;
      cnt      <= CW'(XLEN/STEPS);
      is_div_q <= is_div;
    end else if (calc) begin
      acc <= acc_nxt;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M sequencer beside the EX ALU: captures operands, drives muldiv_core,
// fixes up signs, and holds the pipeline until the result is handed off.
module muldiv_sequencer
  import rv32i_types::*;
#(
  parameter int XLEN  = 32,
  parameter int STEPS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            ex_advance,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN/STEPS+1);
  localparam logic [XLEN-1:0] OVF_DIVIDEND = XLEN'(DIV_OVF_DIVIDEND);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t            state;
  muldiv_funct3_t    f, op;
  logic              neg;
  logic              s1, s2, is_div, sign_in, special, load;
  logic [XLEN-1:0]   a_mag, b_mag, special_val, fix_val;
  logic [2*XLEN-1:0] acc, prod;
  logic [CW-1:0]     cnt;

  assign f      = muldiv_funct3_t'(funct3);
  assign is_div = funct3[2];
  assign s1     = rs1_val[XLEN-1] && (f inside {mul, mulh, mulhsu, div, rem});
  assign s2     = rs2_val[XLEN-1] && (f inside {mul, mulh, div, rem});
  assign a_mag  = s1 ? -rs1_val : rs1_val;
  assign b_mag  = s2 ? -rs2_val : rs2_val;
  // remainder takes the dividend's sign, everything else the xor
  assign sign_in = (f inside {rem}) ? s1 : (s1 ^ s2);

  always_comb begin
    special     = 1'b0;
    special_val = '0;
    if (is_div && rs2_val == '0) begin
      special     = 1'b1;
      special_val = (f inside {div, divu}) ? '1 : rs1_val;
    end else if ((f inside {div, rem}) && rs1_val == OVF_DIVIDEND && rs2_val == '1) begin
      special     = 1'b1;
      special_val = (f == div) ? OVF_DIVIDEND : '0;
    end
  end

  // full-width negate so the high word of a signed product carries correctly
  assign prod = neg ? -acc : acc;

  always_comb begin
    fix_val = '0;
    case (op)
      mul:                 fix_val = prod[XLEN-1:0];
      mulh, mulhsu, mulhu: fix_val = prod[2*XLEN-1:XLEN];
      div, divu:           fix_val = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      default:             fix_val = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    endcase
  end

  assign load  = (state == IDLE) && start && !flush;
  assign stall = start && (state != DONE);

  muldiv_core #(.XLEN(XLEN), .STEPS(STEPS)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .is_div  (is_div),
    .init_lo (is_div ? a_mag : b_mag),
    .init_m  (is_div ? b_mag : a_mag),
    .calc    (state == CALC),
    .acc     (acc),
    .cnt     (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= '0;
      op     <= mul;
      neg    <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op  <= f;
          neg <= sign_in;
          if (special) begin
            result <= special_val;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: if (cnt == CW'(1)) state <= FIXUP;
        FIXUP: begin
          result <= fix_val;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: if (ex_advance) begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against a plain-arithmetic RV32M model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, flush, ex_advance;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic        stall, done;
  logic [31:0] result;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32), .STEPS(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .funct3     (funct3),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .ex_advance (ex_advance),
    .flush      (flush),
    .stall      (stall),
    .done       (done),
    .result     (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Call at posedge+1; cycle 0 is the current cycle. Ends one cycle after ex_advance.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int          cyc;
    bit          stall_ok;
    logic [31:0] exp;
    exp = ref_res(f, a, b);
    funct3 = f; rs1_val = a; rs2_val = b; start = 1'b1; ex_advance = 1'b0;
    cyc = 0; stall_ok = 1'b1;
    while (cyc < 200) begin
      @(negedge clk);
      if (done) break;
      if (!stall) stall_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".lat"}, cyc, ref_lat(f, a, b));
    check({tag, ".stall_busy"}, {31'b0, stall_ok}, 32'd1);
    check({tag, ".res"}, result, exp);
    check({tag, ".stall_done"}, {31'b0, stall}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, ".hold_done"}, {31'b0, done}, 32'd1);
      check({tag, ".hold_res"}, result, exp);
      check({tag, ".hold_stall"}, {31'b0, stall}, 32'd0);
    end
    ex_advance = 1'b1;
    @(posedge clk); #1;
    ex_advance = 1'b0;
    start = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] c[4];
    c[0] = 32'h0; c[1] = 32'h1; c[2] = 32'hFFFF_FFFF; c[3] = 32'h8000_0000;
    case ($urandom_range(0, 3))
      0: return c[$urandom_range(0, 3)];
      1: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; ex_advance = 1'b0;
    funct3 = 3'd0; rs1_val = '0; rs2_val = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst.done", {31'b0, done}, 32'd0);
    check("rst.res", result, 32'd0);
    check("rst.stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;

    run_op("mul7x-3", 3'd0, 32'd7, -32'sd3, 0);
    @(negedge clk);
    check("mul.idle_done", {31'b0, done}, 32'd0);
    check("mul.idle_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;

    run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div-7/2", 3'd4, -32'sd7, 32'd2, 0);
    run_op("rem-7/2", 3'd6, -32'sd7, 32'd2, 0);
    run_op("divu/0", 3'd5, 32'd100, 32'd0, 0);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("hold", 3'd5, 32'd1000, 32'd7, 5);

    // flush mid-divide
    funct3 = 3'd4; rs1_val = 32'd12345; rs2_val = 32'd7; start = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("flush.done", {31'b0, done}, 32'd0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen++; end
    check("flush.no_done", seen, 32'd0);
    @(posedge clk); #1;

    // reset in the middle of a multiply
    funct3 = 3'd0; rs1_val = 32'd99; rs2_val = 32'd3; start = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid.res", result, 32'd0);
    check("rstmid.done", {31'b0, done}, 32'd0);
    check("rstmid.stall", {31'b0, stall}, 32'd1);
    start = 1'b0;
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen++; end
    check("rstmid.no_done", seen, 32'd0);
    @(posedge clk); #1;

    run_op("b2b.mul", 3'd0, 32'd12, 32'd11, 0);
    run_op("b2b.divu", 3'd5, 32'hFFFF_FFFF, 32'd16, 0);

    for (int n = 0; n < 40; n++) begin
      logic [2:0]  rf;
      logic [31:0] ra, rb;
      rf = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      run_op($sformatf("rnd%0d.f%0d", n, rf), rf, ra, rb, $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
